// File: rtl/ahb2apb_bridge_if.sv
// AHB slave request/response and APB initiator signals bundled for the bridge.
// The slave modport is the bridge's view; master is the bus/testbench view.
interface ahb2apb_bridge_if #(
    parameter int ADDR_WID = 32,
    parameter int DATA_WID = 32
);
    // AHB side
    logic                hsel;
    logic [ADDR_WID-1:0] haddr;
    logic [1:0]          htrans;
    logic                hwrite;
    logic [DATA_WID-1:0] hwdata;
    logic                hready;
    logic                hreadyout;
    logic                hresp;
    logic [DATA_WID-1:0] hrdata;
    // APB side
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [ADDR_WID-1:0] paddr;
    logic [DATA_WID-1:0] pwdata;
    logic [DATA_WID-1:0] prdata;
    logic                pready;
    logic                pslverr;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hwdata, hready,
        output hreadyout, hresp, hrdata,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hwdata, hready,
        input  hreadyout, hresp, hrdata,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/ahb2apb_bridge.sv
// AHB-to-APB bridge. Captures one AHB transfer, waits for an APB clock-edge
// strobe (pclken), then runs the APB SETUP/ACCESS phases and returns the
// response on AHB. Every output is registered; all logic runs on hclk.
module ahb2apb_bridge #(
    parameter int ADDR_WID = 32,
    parameter int DATA_WID = 32
) (
    input  logic             hclk,
    input  logic             hresetn,
    input  logic             pclken,
    ahb2apb_bridge_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        ERR    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_WID-1:0] addr_q, addr_d;
    logic                write_q, write_d;

    logic                hreadyout_q, hreadyout_d;
    logic                hresp_q, hresp_d;
    logic [DATA_WID-1:0] hrdata_q, hrdata_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_WID-1:0] paddr_q, paddr_d;
    logic [DATA_WID-1:0] pwdata_q, pwdata_d;

    // htrans[0] only separates NONSEQ from SEQ, which the bridge treats alike
    logic htrans_unused;
    assign htrans_unused = bus.htrans[0];

    logic capture;
    assign capture = bus.hsel && bus.htrans[1] && bus.hready && hreadyout_q;

    // Next-state and next-output logic; everything holds unless changed
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        write_d     = write_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        hrdata_d    = hrdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;

        case (state_q)
            IDLE: begin
                // hresp left high by ERR drops here after its single IDLE cycle
                hreadyout_d = 1'b1;
                hresp_d     = 1'b0;
                if (capture) begin
                    state_d     = WAIT;
                    addr_d      = bus.haddr;
                    write_d     = bus.hwrite;
                    hreadyout_d = 1'b0;
                end
            end
            WAIT: begin
                // hwdata is in its data phase and held stable while stalled
                if (pclken) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    paddr_d   = addr_q;
                    pwrite_d  = write_q;
                    pwdata_d  = bus.hwdata;
                end
            end
            SETUP: begin
                if (pclken) begin
                    state_d   = ACCESS;
                    penable_d = 1'b1;
                end
            end
            ACCESS: begin
                if (pclken && bus.pready) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    if (bus.pslverr) begin
                        state_d     = ERR;
                        hresp_d     = 1'b1;
                        hreadyout_d = 1'b0;
                    end else begin
                        state_d     = IDLE;
                        hresp_d     = 1'b0;
                        hreadyout_d = 1'b1;
                        if (!write_q) hrdata_d = bus.prdata;
                    end
                end
            end
            ERR: begin
                // second cycle of the two-cycle AHB error response
                state_d     = IDLE;
                hresp_d     = 1'b1;
                hreadyout_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                hreadyout_d = 1'b1;
                hresp_d     = 1'b0;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
        end
    end

    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;
    assign bus.hrdata    = hrdata_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed self-checking bench for ahb2apb_bridge. Inputs change 1 ns after
// the rising edge; outputs are sampled at the same point.
module tb_ahb2apb_bridge;

    logic hclk = 1'b0;
    logic hresetn;
    logic pclken;
    int   n_chk  = 0;
    int   n_pass = 0;

    ahb2apb_bridge_if #(.ADDR_WID(32), .DATA_WID(32)) bus ();

    // single-slave system: the master sees this slave's hreadyout as hready
    assign bus.hready = bus.hreadyout;

    ahb2apb_bridge #(.ADDR_WID(32), .DATA_WID(32)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .pclken  (pclken),
        .bus     (bus.slave)
    );

    always #5 hclk = ~hclk;

    task automatic tick;
        @(posedge hclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic req(input logic [31:0] addr, input logic wr);
        bus.hsel   = 1'b1;
        bus.htrans = 2'b10;
        bus.haddr  = addr;
        bus.hwrite = wr;
    endtask

    task automatic noreq;
        bus.hsel   = 1'b0;
        bus.htrans = 2'b00;
    endtask

    initial begin
        hresetn     = 1'b0;
        pclken      = 1'b1;
        bus.hsel    = 1'b0;
        bus.haddr   = '0;
        bus.htrans  = 2'b00;
        bus.hwrite  = 1'b0;
        bus.hwdata  = '0;
        bus.prdata  = '0;
        bus.pready  = 1'b1;
        bus.pslverr = 1'b0;

        // ---- reset state
        tick; tick;
        chk("rst_hreadyout", bus.hreadyout, 1);
        chk("rst_hresp",     bus.hresp,     0);
        chk("rst_hrdata",    bus.hrdata,    0);
        chk("rst_psel",      bus.psel,      0);
        chk("rst_penable",   bus.penable,   0);
        chk("rst_pwrite",    bus.pwrite,    0);
        chk("rst_paddr",     bus.paddr,     0);
        chk("rst_pwdata",    bus.pwdata,    0);
        hresetn = 1'b1;
        tick;

        // ---- BUSY htrans is ignored
        bus.hsel = 1'b1; bus.htrans = 2'b01; bus.haddr = 32'h8;
        tick; tick;
        chk("busy_hreadyout", bus.hreadyout, 1);
        chk("busy_psel",      bus.psel,      0);
        chk("busy_hresp",     bus.hresp,     0);
        noreq;

        // ---- minimum latency write, pclken tied high
        req(32'h10, 1'b1);
        tick;                                   // capture -> WAIT
        noreq; bus.hwdata = 32'hA5A5_0001;
        chk("w1_wait_hreadyout", bus.hreadyout, 0);
        chk("w1_wait_psel",      bus.psel,      0);
        tick;                                   // SETUP
        chk("w1_setup_psel",    bus.psel,    1);
        chk("w1_setup_penable", bus.penable, 0);
        chk("w1_setup_paddr",   bus.paddr,   32'h10);
        chk("w1_setup_pwrite",  bus.pwrite,  1);
        chk("w1_setup_pwdata",  bus.pwdata,  32'hA5A5_0001);
        chk("w1_setup_hready",  bus.hreadyout, 0);
        tick;                                   // ACCESS
        chk("w1_acc_psel",    bus.psel,      1);
        chk("w1_acc_penable", bus.penable,   1);
        chk("w1_acc_hready",  bus.hreadyout, 0);
        tick;                                   // completion
        chk("w1_done_psel",    bus.psel,      0);
        chk("w1_done_penable", bus.penable,   0);
        chk("w1_done_hready",  bus.hreadyout, 1);
        chk("w1_done_hresp",   bus.hresp,     0);

        // ---- read with pclken every 4th cycle
        pclken = 1'b0;
        req(32'h20, 1'b0);
        tick;                                   // capture
        noreq;
        tick; tick;
        chk("r2_wait_psel",   bus.psel,      0);
        chk("r2_wait_hready", bus.hreadyout, 0);
        pclken = 1'b1; tick; pclken = 1'b0;     // SETUP on strobe
        chk("r2_setup_psel",    bus.psel,    1);
        chk("r2_setup_penable", bus.penable, 0);
        chk("r2_setup_paddr",   bus.paddr,   32'h20);
        chk("r2_setup_pwrite",  bus.pwrite,  0);
        tick; tick; tick;
        chk("r2_setup_hold_penable", bus.penable, 0);
        bus.prdata = 32'h1234_5678;
        pclken = 1'b1; tick; pclken = 1'b0;     // ACCESS on strobe
        chk("r2_acc_penable", bus.penable, 1);
        tick; tick; tick;
        chk("r2_acc_hold_hready",  bus.hreadyout, 0);
        chk("r2_acc_hold_penable", bus.penable,   1);
        pclken = 1'b1; tick;                    // completion
        chk("r2_done_hready", bus.hreadyout, 1);
        chk("r2_done_hrdata", bus.hrdata,    32'h1234_5678);
        chk("r2_done_psel",   bus.psel,      0);

        // ---- pready stall for 3 strobes
        req(32'h40, 1'b1);
        tick;
        noreq; bus.hwdata = 32'hDEAD_BEEF;
        tick;                                   // SETUP
        bus.pready = 1'b0;
        tick;                                   // ACCESS
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("st_psel",    bus.psel,      1);
            chk("st_penable", bus.penable,   1);
            chk("st_paddr",   bus.paddr,     32'h40);
            chk("st_pwdata",  bus.pwdata,    32'hDEAD_BEEF);
            chk("st_hready",  bus.hreadyout, 0);
        end
        bus.pready = 1'b1;
        tick;
        chk("st_done_hready", bus.hreadyout, 1);
        chk("st_done_psel",   bus.psel,      0);
        chk("st_done_hrdata", bus.hrdata,    32'h1234_5678);
        tick;
        chk("st_single_psel",   bus.psel,      0);
        chk("st_single_hready", bus.hreadyout, 1);

        // ---- slave error response
        req(32'h50, 1'b0);
        tick;
        noreq;
        tick; tick;                             // SETUP, ACCESS
        bus.pslverr = 1'b1;
        tick;                                   // ERR
        bus.pslverr = 1'b0;
        chk("er1_hresp",   bus.hresp,     1);
        chk("er1_hready",  bus.hreadyout, 0);
        chk("er1_psel",    bus.psel,      0);
        chk("er1_penable", bus.penable,   0);
        tick;
        chk("er2_hresp",  bus.hresp,     1);
        chk("er2_hready", bus.hreadyout, 1);
        tick;
        chk("er3_hresp",  bus.hresp,     0);
        chk("er3_hready", bus.hreadyout, 1);

        // ---- back-to-back write 0x30 then read 0x34
        req(32'h30, 1'b1);
        tick;                                   // capture write
        bus.hwdata = 32'h1111_2222;
        req(32'h34, 1'b0);                      // next address held during data phase
        tick;                                   // SETUP
        chk("bb_w_pwdata", bus.pwdata, 32'h1111_2222);
        chk("bb_w_paddr",  bus.paddr,  32'h30);
        tick;                                   // ACCESS
        tick;                                   // write completes
        chk("bb_w_done_hready", bus.hreadyout, 1);
        tick;                                   // read captured in completion cycle
        noreq;
        chk("bb_r_captured", bus.hreadyout, 0);
        bus.prdata = 32'hCAFE_F00D;
        tick;                                   // SETUP
        chk("bb_r_paddr",  bus.paddr,  32'h34);
        chk("bb_r_pwrite", bus.pwrite, 0);
        tick;                                   // ACCESS
        tick;                                   // read completes
        chk("bb_r_done_hready", bus.hreadyout, 1);
        chk("bb_r_done_hrdata", bus.hrdata,    32'hCAFE_F00D);

        // ---- reset during ACCESS
        req(32'h60, 1'b1);
        tick;
        noreq; bus.hwdata = 32'h5555_AAAA;
        bus.pready = 1'b0;
        tick; tick;                             // SETUP, ACCESS
        chk("ra_acc_penable", bus.penable, 1);
        hresetn = 1'b0;
        tick;
        chk("ra_psel",    bus.psel,      0);
        chk("ra_penable", bus.penable,   0);
        chk("ra_hready",  bus.hreadyout, 1);
        chk("ra_hresp",   bus.hresp,     0);
        chk("ra_paddr",   bus.paddr,     0);
        chk("ra_hrdata",  bus.hrdata,    0);
        hresetn = 1'b1;
        bus.pready = 1'b1;
        tick; tick;
        chk("ra_after_psel",   bus.psel,      0);
        chk("ra_after_hready", bus.hreadyout, 1);
        chk("ra_after_hresp",  bus.hresp,     0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
